// File: rtl/bram_port_arbiter_pkg.sv
// rtl/bram_port_arbiter_pkg.sv - shared constants, state encoding and helpers for the BRAM port arbiter
package bram_arb_pkg;

  localparam logic [3:0] BRAM_WE_FULL = 4'hF;
  localparam logic [3:0] BRAM_WE_NONE = 4'h0;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Never returns less than 1 so single-bit ids and counters stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_if.sv
// rtl/bram_port_arbiter_if.sv - requester handshake and BRAM port bundle
interface bram_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*32-1:0]     req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [31:0]               rsp_rdata;
  logic [31:0]               BRAM_ADDR;
  logic [31:0]               BRAM_WRDATA;
  logic [3:0]                BRAM_WE;
  logic [31:0]               BRAM_RDDATA;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, BRAM_RDDATA,
    output req_ready, rsp_valid, rsp_rdata, BRAM_ADDR, BRAM_WRDATA, BRAM_WE
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, BRAM_RDDATA,
    input  req_ready, rsp_valid, rsp_rdata, BRAM_ADDR, BRAM_WRDATA, BRAM_WE
  );

endinterface

// File: rtl/bram_port_arbiter_rr_picker.sv
// rtl/bram_port_arbiter_rr_picker.sv - combinational round-robin picker
// Searches from ptr+1 upward, wrapping, and returns the first set request.
module rr_picker
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     id_o
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        id_o         = idx;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin BRAM port arbiter with burst locking
// Read responses are steered back to their issuer through an id-tagged pipeline.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 64,
  parameter int ADDR_W     = 32
) (
  input  logic                aclk,
  input  logic                areset,
  bram_port_arbiter_if.slave  bus,
  output logic                busy
);

  localparam int IDW = clog2(NUM_REQ);
  localparam int CW  = clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  arb_state_e          state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d, owner_q, owner_d, gnt_id;
  logic [CW-1:0]       burst_cnt_q, burst_cnt_d;
  logic [NUM_REQ-1:0]  owner_oh, eligible, gnt_raw, gnt;
  logic                accept, acc_we, acc_lock;
  logic [ADDR_W-1:0]   acc_addr;
  logic [31:0]         acc_wdata;
  logic [31:0]         addr_q, wdata_q;
  logic [3:0]          we_q;
  logic [RD_LATENCY:0] tag_v_q;
  logic [IDW-1:0]      tag_id_q [RD_LATENCY+1];

  assign owner_oh = NUM_REQ'(1) << owner_q;
  assign eligible = (state_q == LOCKED) ? (bus.req_valid & owner_oh) : bus.req_valid;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_picker (
    .req_i   (eligible),
    .ptr_i   (ptr_q),
    .grant_o (gnt_raw),
    .id_o    (gnt_id)
  );

  // Grants are suppressed while reset is held so req_ready reads 0 during reset.
  assign gnt           = areset ? '0 : gnt_raw;
  assign bus.req_ready = gnt;
  assign accept        = |gnt;
  assign acc_we        = bus.req_we[gnt_id];
  assign acc_lock      = bus.req_lock[gnt_id];
  assign acc_addr      = bus.req_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
  assign acc_wdata     = bus.req_wdata[int'(gnt_id)*32 +: 32];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (accept) begin
      ptr_d = gnt_id;
      unique case (state_q)
        ARB: begin
          if (acc_lock) begin
            state_d     = LOCKED;
            owner_d     = gnt_id;
            burst_cnt_d = CW'(1);
          end
        end
        LOCKED: begin
          if (!acc_lock) begin
            state_d     = ARB;
            burst_cnt_d = '0;
          end else if (burst_cnt_q == LAST_BEAT) begin
            // Burst window exhausted: yield only if someone else is waiting.
            burst_cnt_d = '0;
            if (|(bus.req_valid & ~owner_oh)) state_d = ARB;
          end else begin
            burst_cnt_d = burst_cnt_q + CW'(1);
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= ARB;
      ptr_q       <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= BRAM_WE_NONE;
    end else if (accept) begin
      addr_q  <= 32'(acc_addr);
      wdata_q <= acc_wdata;
      we_q    <= acc_we ? BRAM_WE_FULL : BRAM_WE_NONE;
    end else begin
      we_q    <= BRAM_WE_NONE;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tag_v_q <= '0;
      for (int k = 0; k <= RD_LATENCY; k++) tag_id_q[k] <= '0;
    end else begin
      tag_v_q     <= {tag_v_q[RD_LATENCY-1:0], accept & ~acc_we};
      tag_id_q[0] <= gnt_id;
      for (int k = 1; k <= RD_LATENCY; k++) tag_id_q[k] <= tag_id_q[k-1];
    end
  end

  assign bus.BRAM_ADDR   = addr_q;
  assign bus.BRAM_WRDATA = wdata_q;
  assign bus.BRAM_WE     = we_q;
  assign bus.rsp_valid   = tag_v_q[RD_LATENCY] ? (NUM_REQ'(1) << tag_id_q[RD_LATENCY]) : '0;
  assign bus.rsp_rdata   = tag_v_q[RD_LATENCY] ? bus.BRAM_RDDATA : '0;
  assign busy            = (we_q != BRAM_WE_NONE) || (|tag_v_q);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - directed self-checking bench for bram_port_arbiter
// BRAM model: one-cycle registered read, word index = addr[7:2], reset fills word i with A000_0000+i.
module tb_bram_port_arbiter;

  logic aclk;
  logic areset;
  logic busy;
  int   n_checks;
  int   n_err;
  int   beats0;
  logic [31:0] mem [64];

  bram_port_arbiter_if #(.NUM_REQ(2), .ADDR_W(32)) bus ();

  bram_port_arbiter #(
    .NUM_REQ(2), .RD_LATENCY(1), .MAX_BURST(64), .ADDR_W(32)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      bus.BRAM_RDDATA <= '0;
    end else begin
      if (bus.BRAM_WE != 4'h0) mem[bus.BRAM_ADDR[7:2]] <= bus.BRAM_WRDATA;
      bus.BRAM_RDDATA <= mem[bus.BRAM_ADDR[7:2]];
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid[i]          = v;
    bus.req_we[i]             = we;
    bus.req_lock[i]           = lock;
    bus.req_addr[i*32 +: 32]  = addr;
    bus.req_wdata[i*32 +: 32] = wdata;
  endtask

  initial begin
    n_checks      = 0;
    n_err         = 0;
    beats0        = 0;
    aclk          = 1'b0;
    areset        = 1'b1;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset state, with a request asserted to show req_ready stays low.
    tick();
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    chk("rst_ready", bus.req_ready, 32'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_addr", bus.BRAM_ADDR, 32'h0);
    chk("rst_wdata", bus.BRAM_WRDATA, 32'h0);
    chk("rst_we", bus.BRAM_WE, 32'h0);
    chk("rst_busy", busy, 32'h0);
    bus.req_valid = '0;
    areset        = 1'b0;

    // Requester 0 alone: four reads back to back.
    for (int c = 0; c < 7; c++) begin
      tick();
      if (c < 4) set_req(0, 1'b1, 1'b0, 1'b0, 32'(4 * c), 32'h0);
      else bus.req_valid = '0;
      settle();
      if (c < 4) chk("t1_ready", bus.req_ready, 32'h1);
      if (c >= 1 && c <= 4) begin
        chk("t1_addr", bus.BRAM_ADDR, 32'(4 * (c - 1)));
        chk("t1_we", bus.BRAM_WE, 32'h0);
      end
      if (c >= 2 && c <= 5) begin
        chk("t1_rsp_valid", bus.rsp_valid, 32'h1);
        chk("t1_rsp_rdata", bus.rsp_rdata, 32'hA000_0000 + 32'(c - 2));
      end else begin
        chk("t1_rsp_idle", bus.rsp_valid, 32'h0);
      end
    end
    chk("t1_busy_idle", busy, 32'h0);

    // Two continuous requesters, no lock: grants alternate 1,0,1,0.
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c < 4) begin
        set_req(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        set_req(1, 1'b1, 1'b0, 1'b0, 32'h24, 32'h0);
      end else begin
        bus.req_valid = '0;
      end
      settle();
      if (c < 4) chk("t2_ready", bus.req_ready, (c % 2 == 0) ? 32'h2 : 32'h1);
      if (c >= 1 && c <= 4) chk("t2_addr", bus.BRAM_ADDR, ((c - 1) % 2 == 0) ? 32'h24 : 32'h20);
      if (c >= 2) begin
        chk("t2_rsp_valid", bus.rsp_valid, ((c - 2) % 2 == 0) ? 32'h2 : 32'h1);
        chk("t2_rsp_rdata", bus.rsp_rdata, ((c - 2) % 2 == 0) ? 32'hA000_0009 : 32'hA000_0008);
      end
    end

    // Requester 0 locks for 70 beats while requester 1 waits: forced yield after 64.
    for (int c = 0; c <= 70; c++) begin
      tick();
      set_req(0, 1'b1, 1'b0, (c != 70), 32'h40, 32'h0);
      if (c >= 1 && c <= 64) set_req(1, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0);
      else bus.req_valid[1] = 1'b0;
      settle();
      chk("t3_ready", bus.req_ready, (c == 64) ? 32'h2 : 32'h1);
      if (bus.req_ready[0]) beats0++;
    end
    tick();
    bus.req_valid = '0;
    settle();
    chk("t3_beats0", beats0, 32'd70);
    repeat (3) tick();

    // Write by requester 1, then read of the same word by requester 0.
    tick();
    set_req(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
    settle();
    chk("t4_wr_ready", bus.req_ready, 32'h2);
    tick();
    bus.req_valid[1] = 1'b0;
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    settle();
    chk("t4_rd_ready", bus.req_ready, 32'h1);
    chk("t4_we_full", bus.BRAM_WE, 32'hF);
    chk("t4_wr_addr", bus.BRAM_ADDR, 32'h10);
    chk("t4_wr_data", bus.BRAM_WRDATA, 32'hDEAD_BEEF);
    chk("t4_wr_norsp", bus.rsp_valid, 32'h0);
    tick();
    bus.req_valid = '0;
    settle();
    chk("t4_we_none", bus.BRAM_WE, 32'h0);
    chk("t4_rd_addr", bus.BRAM_ADDR, 32'h10);
    chk("t4_rsp_early", bus.rsp_valid, 32'h0);
    tick();
    settle();
    chk("t4_rsp_valid", bus.rsp_valid, 32'h1);
    chk("t4_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);

    // Read then write of the same word: read must see the old value.
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h18, 32'h0);
    settle();
    chk("t4b_rd_ready", bus.req_ready, 32'h1);
    tick();
    bus.req_valid[0] = 1'b0;
    set_req(1, 1'b1, 1'b1, 1'b0, 32'h18, 32'h1234_5678);
    settle();
    chk("t4b_wr_ready", bus.req_ready, 32'h2);
    tick();
    bus.req_valid = '0;
    settle();
    chk("t4b_rsp_valid", bus.rsp_valid, 32'h1);
    chk("t4b_rsp_old", bus.rsp_rdata, 32'hA000_0006);
    chk("t4b_we_full", bus.BRAM_WE, 32'hF);
    tick();
    settle();
    chk("t4b_rsp_done", bus.rsp_valid, 32'h0);

    // Locked owner stalls for three cycles; requester 1 must not be granted.
    tick();
    set_req(0, 1'b1, 1'b0, 1'b1, 32'h00, 32'h0);
    settle();
    chk("t5_lock_ready", bus.req_ready, 32'h1);
    for (int c = 0; c < 3; c++) begin
      tick();
      bus.req_valid[0] = 1'b0;
      set_req(1, 1'b1, 1'b0, 1'b0, 32'h04, 32'h0);
      settle();
      chk("t5_stall_ready", bus.req_ready, 32'h0);
      if (c > 0) chk("t5_stall_we", bus.BRAM_WE, 32'h0);
    end
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h00, 32'h0);
    settle();
    chk("t5_resume_ready", bus.req_ready, 32'h1);
    tick();
    bus.req_valid[0] = 1'b0;
    settle();
    chk("t5_release_ready", bus.req_ready, 32'h2);
    tick();
    bus.req_valid = '0;
    repeat (3) tick();

    // Reset pulse with two reads in flight.
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h00, 32'h0);
    settle();
    chk("t6_rd0_ready", bus.req_ready, 32'h1);
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h04, 32'h0);
    settle();
    chk("t6_rd1_ready", bus.req_ready, 32'h1);
    tick();
    bus.req_valid = '0;
    areset        = 1'b1;
    settle();
    chk("t6_async_addr", bus.BRAM_ADDR, 32'h0);
    chk("t6_async_we", bus.BRAM_WE, 32'h0);
    chk("t6_async_rsp", bus.rsp_valid, 32'h0);
    chk("t6_async_rdata", bus.rsp_rdata, 32'h0);
    chk("t6_async_busy", busy, 32'h0);
    tick();
    areset = 1'b0;
    settle();
    for (int c = 0; c < 3; c++) begin
      chk("t6_post_rsp", bus.rsp_valid, 32'h0);
      chk("t6_post_busy", busy, 32'h0);
      tick();
    end
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h00, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h04, 32'h0);
    settle();
    chk("t6_ptr_reset", bus.req_ready, 32'h2);
    bus.req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
